// File: rtl/beta_mem_bridge.sv
// Memory-port bridge for the beta2 core: decodes ma into a synchronous RAM port
// and an I/O page (timer, interrupt controller, GPIO); read data returns one cycle later.
module beta_mem_bridge #(
   parameter int          RAM_AW    = 14,
   parameter logic [31:0] IO_BASE   = 32'h7FFFF000,
   parameter logic [30:0] VEC_RESET = 31'h00000008
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ma,
   input  logic [31:0]       mdout,
   input  logic              mwe,
   output logic [31:0]       mdin,
   output logic              irq,
   output logic [30:0]       xadr,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic              ext_evt,
   input  logic [15:0]       gpio_in,
   output logic [15:0]       gpio_out
);

   typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_IO} sel_t;

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_RELOAD = 3'd1;
   localparam logic [2:0] OFF_COUNT  = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_MASK   = 3'd4;
   localparam logic [2:0] OFF_VECTOR = 3'd5;
   localparam logic [2:0] OFF_GPO    = 3'd6;
   localparam logic [2:0] OFF_GPI    = 3'd7;

   // Registers
   sel_t        r_sel;
   logic [31:0] r_io_q;
   logic [2:0]  r_ctrl;
   logic [31:0] r_reload;
   logic [31:0] r_count;
   logic [1:0]  r_status;
   logic [1:0]  r_mask;
   logic [30:0] r_vector;
   logic [15:0] r_gpo;
   logic [15:0] r_gpi_s1, r_gpi_s2;
   logic        r_ext_s1, r_ext_s2, r_ext_d;
   logic        r_irq;

   // Wires
   logic        w_io_sel, w_ram_sel, w_io_hit, w_io_wr;
   logic [2:0]  w_off;
   logic        w_wr_ctrl, w_wr_reload, w_wr_count, w_wr_status;
   logic        w_wr_mask, w_wr_vector, w_wr_gpo;
   logic        w_en, w_auto, w_tmr_hit, w_ext_rise;
   logic [1:0]  w_set, w_clr;
   logic [31:0] w_io_rdata;
   logic        w_unused;

   // Supervisor bit and byte offset never take part in decode.
   assign w_unused = ^{ma[31], ma[1:0]};

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   assign w_io_sel  = (ma[30:12] == IO_BASE[30:12]);
   assign w_ram_sel = ~w_io_sel & (ma[30:RAM_AW+2] == '0);
   assign w_io_hit  = w_io_sel & (ma[11:5] == 7'd0);
   assign w_io_wr   = mwe & w_io_hit;
   assign w_off     = ma[4:2];

   assign w_wr_ctrl   = w_io_wr & (w_off == OFF_CTRL);
   assign w_wr_reload = w_io_wr & (w_off == OFF_RELOAD);
   assign w_wr_count  = w_io_wr & (w_off == OFF_COUNT);
   assign w_wr_status = w_io_wr & (w_off == OFF_STATUS);
   assign w_wr_mask   = w_io_wr & (w_off == OFF_MASK);
   assign w_wr_vector = w_io_wr & (w_off == OFF_VECTOR);
   assign w_wr_gpo    = w_io_wr & (w_off == OFF_GPO);

   assign ram_addr  = ma[RAM_AW+1:2];
   assign ram_we    = mwe & w_ram_sel;
   assign ram_wdata = mdout;

   // ------------------------------------------------------------------
   // Timer
   // ------------------------------------------------------------------
   assign w_en      = r_ctrl[0];
   assign w_auto    = r_ctrl[2];
   assign w_tmr_hit = w_en & (r_count == 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_wr_count) begin
         r_count <= mdout;
      end else if (w_en) begin
         if (r_count != 32'd0)
            r_count <= r_count - 32'd1;
         else if (w_auto)
            r_count <= r_reload;
      end
   end

   // A CTRL write in the cycle of a one-shot expiry wins over the auto-clear of en.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_ctrl <= '0;
      else if (w_wr_ctrl)
         r_ctrl <= {mdout[2], 1'b0, mdout[0]};
      else if (w_tmr_hit && !w_auto)
         r_ctrl[0] <= 1'b0;
   end

   // ------------------------------------------------------------------
   // Synchronizers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ext_s1 <= 1'b0;
         r_ext_s2 <= 1'b0;
         r_ext_d  <= 1'b0;
         r_gpi_s1 <= '0;
         r_gpi_s2 <= '0;
      end else begin
         r_ext_s1 <= ext_evt;
         r_ext_s2 <= r_ext_s1;
         r_ext_d  <= r_ext_s2;
         r_gpi_s1 <= gpio_in;
         r_gpi_s2 <= r_gpi_s1;
      end
   end

   assign w_ext_rise = r_ext_s2 & ~r_ext_d;

   // ------------------------------------------------------------------
   // Status / interrupt controller
   // ------------------------------------------------------------------
   assign w_set = {w_ext_rise, w_tmr_hit};
   assign w_clr = w_wr_status ? mdout[1:0] : 2'b00;

   // Set is OR-ed after the clear so a coincident event survives the W1C.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_clr) | w_set;
         r_irq    <= |(r_status & r_mask);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_reload <= '0;
         r_mask   <= '0;
         r_vector <= VEC_RESET;
         r_gpo    <= '0;
      end else begin
         if (w_wr_reload) r_reload <= mdout;
         if (w_wr_mask)   r_mask   <= mdout[1:0];
         if (w_wr_vector) r_vector <= mdout[30:0];
         if (w_wr_gpo)    r_gpo    <= mdout[15:0];
      end
   end

   assign irq      = r_irq;
   assign xadr     = r_vector;
   assign gpio_out = r_gpo;

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   always_comb begin
      w_io_rdata = '0;
      if (w_io_hit) begin
         case (w_off)
            OFF_CTRL:   w_io_rdata = {29'd0, r_ctrl};
            OFF_RELOAD: w_io_rdata = r_reload;
            OFF_COUNT:  w_io_rdata = r_count;
            OFF_STATUS: w_io_rdata = {30'd0, r_status};
            OFF_MASK:   w_io_rdata = {30'd0, r_mask};
            OFF_VECTOR: w_io_rdata = {1'b0, r_vector};
            OFF_GPO:    w_io_rdata = {16'd0, r_gpo};
            OFF_GPI:    w_io_rdata = {16'd0, r_gpi_s2};
            default:    w_io_rdata = '0;
         endcase
      end
   end

   // Sampling pre-edge register values gives read-old-value on same-cycle writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel  <= SEL_NONE;
         r_io_q <= '0;
      end else begin
         r_sel  <= w_io_sel ? SEL_IO : (w_ram_sel ? SEL_RAM : SEL_NONE);
         r_io_q <= w_io_rdata;
      end
   end

   always_comb begin
      mdin = '0;
      case (r_sel)
         SEL_RAM: mdin = ram_rdata;
         SEL_IO:  mdin = r_io_q;
         default: mdin = '0;
      endcase
   end

endmodule

// File: tb/tb_beta_mem_bridge.sv
// Directed bench for beta_mem_bridge: RAM path, decode, timer, interrupts, GPIO, reset.
module tb_beta_mem_bridge;

   localparam logic [31:0] IDLE   = 32'h4000_0000;
   localparam logic [31:0] A_CTRL = 32'h7FFF_F000;
   localparam logic [31:0] A_REL  = 32'h7FFF_F004;
   localparam logic [31:0] A_CNT  = 32'h7FFF_F008;
   localparam logic [31:0] A_STAT = 32'h7FFF_F00C;
   localparam logic [31:0] A_MASK = 32'h7FFF_F010;
   localparam logic [31:0] A_VEC  = 32'h7FFF_F014;
   localparam logic [31:0] A_GPO  = 32'h7FFF_F018;
   localparam logic [31:0] A_GPI  = 32'h7FFF_F01C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ma = IDLE;
   logic [31:0] mdout = '0;
   logic        mwe = 1'b0;
   logic [31:0] mdin;
   logic        irq;
   logic [30:0] xadr;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic        ext_evt = 1'b0;
   logic [15:0] gpio_in = '0;
   logic [15:0] gpio_out;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] mem [0:255];

   beta_mem_bridge dut (
      .clk(clk), .reset(reset), .ma(ma), .mdout(mdout), .mwe(mwe),
      .mdin(mdin), .irq(irq), .xadr(xadr), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ext_evt(ext_evt), .gpio_in(gpio_in), .gpio_out(gpio_out)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model, 1-cycle read latency, read-before-write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[7:0]];
   end

   task automatic cyc(input logic [31:0] a, input logic we, input logic [31:0] d);
      ma = a; mwe = we; mdout = d;
      @(posedge clk); #1;
      ma = IDLE; mwe = 1'b0;
   endtask

   task automatic test_reset;
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL rst_mdin got %h want 0", mdin); end
      vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
      vectors++; if (gpio_out !== 16'd0) begin errors++; $display("FAIL rst_gpo got %h want 0", gpio_out); end
      vectors++; if (xadr !== 31'h8) begin errors++; $display("FAIL rst_xadr got %h want 8", xadr); end
      reset = 1'b0;
      cyc(A_VEC, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'h8) begin errors++; $display("FAIL rst_vec_rd got %h want 8", mdin); end
      cyc(A_CTRL, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'h0) begin errors++; $display("FAIL rst_ctrl_rd got %h want 0", mdin); end
   endtask

   task automatic test_ram;
      ma = 32'h40; mwe = 1'b1; mdout = 32'hDEADBEEF;
      #1;
      vectors++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we got %b want 1", ram_we); end
      vectors++; if (ram_addr !== 14'h10) begin errors++; $display("FAIL ram_addr got %h want 10", ram_addr); end
      vectors++; if (ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_wdata got %h want deadbeef", ram_wdata); end
      @(posedge clk); #1;
      mwe = 1'b0; ma = IDLE;
      cyc(32'h40, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd got %h want deadbeef", mdin); end
      cyc(32'h8000_0040, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd_sup got %h want deadbeef", mdin); end
   endtask

   task automatic test_unmapped;
      ma = 32'h4000_0000; mwe = 1'b1; mdout = 32'h1111_2222;
      #1;
      vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL unm_we got %b want 0", ram_we); end
      @(posedge clk); #1;
      mwe = 1'b0;
      cyc(32'h4000_0000, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL unm_rd got %h want 0", mdin); end
      cyc(32'h7FFF_F020, 1'b1, 32'h0000_00FF);
      cyc(32'h7FFF_F020, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL io_hi_rd got %h want 0", mdin); end
      cyc(A_CTRL, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL io_hi_alias got %h want 0", mdin); end
   endtask

   task automatic test_oneshot;
      cyc(A_CNT, 1'b1, 32'd3);
      cyc(A_MASK, 1'b1, 32'd1);
      cyc(A_CTRL, 1'b1, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         cyc(IDLE, 1'b0, 32'd0);
         vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_early%0d got %b want 0", i, irq); end
      end
      cyc(A_STAT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd1) begin errors++; $display("FAIL os_status got %h want 1", mdin); end
      vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq got %b want 1", irq); end
      cyc(A_CTRL, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL os_en_clr got %h want 0", mdin); end
      cyc(A_CNT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL os_count got %h want 0", mdin); end
      cyc(A_STAT, 1'b1, 32'd1);
      vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq_hold got %b want 1", irq); end
      cyc(IDLE, 1'b0, 32'd0);
      vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_drop got %b want 0", irq); end
   endtask

   task automatic test_autoreload;
      cyc(A_REL, 1'b1, 32'd2);
      cyc(A_CTRL, 1'b1, 32'd5);
      cyc(IDLE, 1'b0, 32'd0);           // hit: count 0 -> 2
      cyc(A_STAT, 1'b1, 32'd1);         // clear, no hit
      cyc(A_STAT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL ar_cleared got %h want 0", mdin); end
      cyc(A_STAT, 1'b1, 32'd1);         // W1C coincides with hit
      cyc(A_STAT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd1) begin errors++; $display("FAIL ar_w1c_hit got %h want 1", mdin); end
      cyc(A_CNT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd1) begin errors++; $display("FAIL ar_count got %h want 1", mdin); end
      cyc(A_CTRL, 1'b1, 32'd0);         // hit reloads 2, then frozen
      cyc(A_CNT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd2) begin errors++; $display("FAIL ar_freeze1 got %h want 2", mdin); end
      cyc(A_CNT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd2) begin errors++; $display("FAIL ar_freeze2 got %h want 2", mdin); end
      cyc(A_STAT, 1'b1, 32'd3);
      cyc(A_STAT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL ar_final got %h want 0", mdin); end
   endtask

   task automatic test_ext_irq;
      cyc(A_MASK, 1'b1, 32'd2);
      cyc(IDLE, 1'b0, 32'd0);
      ext_evt = 1'b1;
      for (int i = 0; i < 3; i++) cyc(IDLE, 1'b0, 32'd0);
      vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL ext_irq_early got %b want 0", irq); end
      cyc(IDLE, 1'b0, 32'd0);
      vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL ext_irq got %b want 1", irq); end
      ext_evt = 1'b0;
      cyc(A_STAT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd2) begin errors++; $display("FAIL ext_status got %h want 2", mdin); end
      vectors++; if (xadr !== 31'h8) begin errors++; $display("FAIL ext_xadr got %h want 8", xadr); end
      cyc(A_VEC, 1'b1, 32'h100);
      vectors++; if (xadr !== 31'h100) begin errors++; $display("FAIL vec_xadr got %h want 100", xadr); end
      cyc(A_STAT, 1'b1, 32'd2);
      cyc(A_STAT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL ext_clr got %h want 0", mdin); end
   endtask

   task automatic test_gpio;
      cyc(A_GPO, 1'b1, 32'h1234);
      vectors++; if (gpio_out !== 16'h1234) begin errors++; $display("FAIL gpo1 got %h want 1234", gpio_out); end
      cyc(A_GPO, 1'b1, 32'h5678);
      vectors++; if (mdin !== 32'h1234) begin errors++; $display("FAIL gpo_old got %h want 1234", mdin); end
      vectors++; if (gpio_out !== 16'h5678) begin errors++; $display("FAIL gpo2 got %h want 5678", gpio_out); end
      cyc(A_GPO, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'h5678) begin errors++; $display("FAIL gpo_rd got %h want 5678", mdin); end
      gpio_in = 16'h3C3C;
      cyc(IDLE, 1'b0, 32'd0);
      cyc(IDLE, 1'b0, 32'd0);
      cyc(A_GPI, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'h3C3C) begin errors++; $display("FAIL gpi_rd got %h want 3c3c", mdin); end
   endtask

   task automatic test_reset_midcount;
      cyc(A_CNT, 1'b1, 32'h50);
      cyc(A_CTRL, 1'b1, 32'd1);
      cyc(A_CNT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'h50) begin errors++; $display("FAIL mc_count got %h want 50", mdin); end
      gpio_in = 16'hA5A5;
      ma = A_CNT;
      #3 reset = 1'b1;
      #1;
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL mc_mdin got %h want 0", mdin); end
      vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL mc_irq got %b want 0", irq); end
      vectors++; if (gpio_out !== 16'd0) begin errors++; $display("FAIL mc_gpo got %h want 0", gpio_out); end
      vectors++; if (xadr !== 31'h8) begin errors++; $display("FAIL mc_xadr got %h want 8", xadr); end
      #1 reset = 1'b0;
      @(posedge clk); #1;
      cyc(A_CNT, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL mc_count_rst got %h want 0", mdin); end
      cyc(A_CTRL, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'd0) begin errors++; $display("FAIL mc_ctrl_rst got %h want 0", mdin); end
      cyc(A_GPI, 1'b0, 32'd0);
      vectors++; if (mdin !== 32'hA5A5) begin errors++; $display("FAIL mc_gpi got %h want a5a5", mdin); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      test_ram;
      test_unmapped;
      test_oneshot;
      test_autoreload;
      test_ext_irq;
      test_gpio;
      test_reset_midcount;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
